mips_cpu: RTL and testbench

MIPS_CPU -- requirements
Module: mips_cpu

---
 rtl/mips_cpu.sv | 131 +++++++++++++
 tb/tb_mips_cpu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// Single-cycle MIPS subset core with internal instruction ROM and data RAM.
// Define CPU_TRACE_EN to print a line per retired instruction and its write.
module mips_cpu #(
   parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
   parameter logic [31:0] DATA_BASE = 32'h0000_0000,
   parameter int          IM_WORDS  = 1024,
   parameter int          DM_WORDS  = 1024
) (
   input  logic clk,
   input  logic rst
);

   localparam int IM_AW = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;
   localparam int DM_AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // Loaded from outside by the testbench; the core only reads it.
   logic [31:0] rom  [0:IM_WORDS-1];
   logic [31:0] dmem [0:DM_WORDS-1];
   logic [31:0] rf   [0:31];
   logic [31:0] pc;
   logic [31:0] inst;

   logic [31:0] pc_next, pc_plus4;
   logic [31:0] im_off, im_idx;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] sext, rs_val, rt_val;
   logic [31:0] dm_addr, dm_idx, dm_rdata;
   logic        dm_ok;
   logic        rf_we, dm_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        unused_shamt;

   // Fetch: anything outside the ROM reads as 0, which decodes as a no-op.
   assign im_off = pc - TEXT_BASE;
   assign im_idx = im_off >> 2;
   assign inst   = (im_idx < 32'(IM_WORDS)) ? rom[im_idx[IM_AW-1:0]] : 32'h0;

   assign op           = inst[31:26];
   assign rs           = inst[25:21];
   assign rt           = inst[20:16];
   assign rd           = inst[15:11];
   assign funct        = inst[5:0];
   assign unused_shamt = ^inst[10:6];
   assign sext         = {{16{inst[15]}}, inst[15:0]};

   assign rs_val = (rs == 5'd0) ? 32'h0 : rf[rs];
   assign rt_val = (rt == 5'd0) ? 32'h0 : rf[rt];

   assign pc_plus4 = pc + 32'd4;

   assign dm_addr  = rs_val + sext - DATA_BASE;
   assign dm_idx   = dm_addr >> 2;
   assign dm_ok    = dm_idx < 32'(DM_WORDS);
   assign dm_rdata = dm_ok ? dmem[dm_idx[DM_AW-1:0]] : 32'h0;

   always_comb begin
      rf_we   = 1'b0;
      rf_wa   = rd;
      rf_wd   = 32'h0;
      dm_we   = 1'b0;
      pc_next = pc_plus4;
      case (op)
         OP_RTYPE: begin
            rf_we = 1'b1;
            case (funct)
               FN_ADD:  rf_wd = rs_val + rt_val;
               FN_SUB:  rf_wd = rs_val - rt_val;
               FN_AND:  rf_wd = rs_val & rt_val;
               FN_OR:   rf_wd = rs_val | rt_val;
               FN_SLT:  rf_wd = {31'h0, $signed(rs_val) < $signed(rt_val)};
               default: rf_we = 1'b0;
            endcase
         end
         OP_ADDI: begin
            rf_we = 1'b1;
            rf_wa = rt;
            rf_wd = rs_val + sext;
         end
         OP_LW: begin
            rf_we = 1'b1;
            rf_wa = rt;
            rf_wd = dm_rdata;
         end
         OP_SW:  dm_we = dm_ok;
         OP_BEQ: if (rs_val == rt_val) pc_next = pc_plus4 + {sext[29:0], 2'b00};
         OP_J:   pc_next = {pc_plus4[31:28], inst[25:0], 2'b00};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= TEXT_BASE;
         for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      end else begin
         pc <= pc_next;
         if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
      end
   end

   // Data RAM is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (rst && dm_we) dmem[dm_idx[DM_AW-1:0]] <= rt_val;
   end

`ifdef CPU_TRACE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         $display("pc=%08h inst=%08h", pc, inst);
         if (rf_we && rf_wa != 5'd0) $display("  r%0d <= %08h", rf_wa, rf_wd);
         if (dm_we) $display("  mem[%08h] <= %08h", dm_addr + DATA_BASE, rt_val);
      end
   end
`endif

endmodule

// File: tb/tb_mips_cpu.sv
// Directed-vector bench for mips_cpu: programs are poked into the ROM and
// architectural state is checked against hand-computed values.
module tb_mips_cpu;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mips_cpu dut (.clk(clk), .rst(rst));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s,
                                         input logic [4:0] t, input logic [4:0] d);
      return {6'h00, s, t, d, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] imm);
      return {o, s, t, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] tgt);
      return {6'h02, tgt};
   endfunction

   task automatic hold_reset_and_clear();
      rst = 1'b0;
      for (int i = 0; i < 1024; i++) dut.rom[i] = 32'h0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic all_zero;
      rst = 1'b0;
      for (int i = 0; i < 1024; i++) dut.rom[i] = 32'h0;
      dut.rom[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      #18;
      checks++;
      if (dut.pc !== 32'h0000_3000) begin
         errors++; $display("FAIL reset_pc got %h want %h", dut.pc, 32'h0000_3000);
      end
      all_zero = 1'b1;
      for (int i = 0; i < 32; i++) if (dut.rf[i] !== 32'h0) all_zero = 1'b0;
      checks++;
      if (all_zero !== 1'b1) begin
         errors++; $display("FAIL reset_rf got nonzero want all zero");
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut.pc !== 32'h0000_3004) begin
         errors++; $display("FAIL first_edge_pc got %h want %h", dut.pc, 32'h0000_3004);
      end
      checks++;
      if (dut.rf[1] !== 32'd5) begin
         errors++; $display("FAIL first_edge_r1 got %h want %h", dut.rf[1], 32'd5);
      end
   endtask

   task automatic test_alu();
      logic [31:0] exp [1:7];
      hold_reset_and_clear();
      dut.rom[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      dut.rom[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
      dut.rom[2] = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
      dut.rom[3] = enc_r(6'h22, 5'd1, 5'd2, 5'd4);
      dut.rom[4] = enc_r(6'h24, 5'd1, 5'd2, 5'd5);
      dut.rom[5] = enc_r(6'h25, 5'd1, 5'd2, 5'd6);
      dut.rom[6] = enc_r(6'h2A, 5'd2, 5'd1, 5'd7);
      dut.rom[7] = enc_r(6'h2A, 5'd1, 5'd2, 5'd8);
      exp[1] = 32'd5;  exp[2] = 32'hFFFF_FFFD; exp[3] = 32'd2; exp[4] = 32'd8;
      exp[5] = 32'd5;  exp[6] = 32'hFFFF_FFFD; exp[7] = 32'd1;
      release_reset();
      run(8);
      for (int r = 1; r <= 7; r++) begin
         checks++;
         if (dut.rf[r] !== exp[r]) begin
            errors++; $display("FAIL alu_r%0d got %h want %h", r, dut.rf[r], exp[r]);
         end
      end
      checks++;
      if (dut.rf[8] !== 32'd0) begin
         errors++; $display("FAIL alu_slt_false got %h want %h", dut.rf[8], 32'd0);
      end
      checks++;
      if (dut.pc !== 32'h0000_3020) begin
         errors++; $display("FAIL alu_pc got %h want %h", dut.pc, 32'h0000_3020);
      end
   endtask

   task automatic test_memory();
      hold_reset_and_clear();
      dut.rom[0] = enc_i(6'h08, 5'd0, 5'd8, 16'h0055);
      dut.rom[1] = enc_i(6'h2B, 5'd0, 5'd8, 16'd80);
      dut.rom[2] = enc_i(6'h23, 5'd0, 5'd9, 16'd80);
      dut.rom[3] = enc_i(6'h2B, 5'd0, 5'd9, 16'd84);
      dut.rom[4] = enc_i(6'h08, 5'd0, 5'd10, 16'd1);
      dut.rom[5] = enc_i(6'h23, 5'd0, 5'd10, 16'h1000);
      dut.rom[6] = enc_i(6'h08, 5'd0, 5'd11, 16'd88);
      dut.rom[7] = enc_i(6'h23, 5'd11, 5'd12, 16'hFFF8);
      dut.rom[8] = enc_i(6'h23, 5'd0, 5'd13, 16'd82);
      release_reset();
      run(9);
      checks++;
      if (dut.dmem[20] !== 32'h55) begin
         errors++; $display("FAIL mem_dmem20 got %h want %h", dut.dmem[20], 32'h55);
      end
      checks++;
      if (dut.rf[9] !== 32'h55) begin
         errors++; $display("FAIL mem_r9 got %h want %h", dut.rf[9], 32'h55);
      end
      checks++;
      if (dut.dmem[21] !== 32'h55) begin
         errors++; $display("FAIL mem_dmem21 got %h want %h", dut.dmem[21], 32'h55);
      end
      checks++;
      if (dut.rf[10] !== 32'h0) begin
         errors++; $display("FAIL mem_lw_oob got %h want %h", dut.rf[10], 32'h0);
      end
      checks++;
      if (dut.rf[12] !== 32'h55) begin
         errors++; $display("FAIL mem_neg_offset got %h want %h", dut.rf[12], 32'h55);
      end
      checks++;
      if (dut.rf[13] !== 32'h55) begin
         errors++; $display("FAIL mem_low_bits got %h want %h", dut.rf[13], 32'h55);
      end
   endtask

   task automatic test_branch_jump();
      logic [31:0] exp_pc [0:7];
      hold_reset_and_clear();
      dut.rom[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
      dut.rom[3] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
      dut.rom[4] = enc_i(6'h04, 5'd1, 5'd0, 16'd5);
      dut.rom[5] = enc_j(26'h000_0C00);
      exp_pc[0] = 32'h300C; exp_pc[1] = 32'h3010; exp_pc[2] = 32'h3014; exp_pc[3] = 32'h3000;
      exp_pc[4] = 32'h300C; exp_pc[5] = 32'h3010; exp_pc[6] = 32'h3014; exp_pc[7] = 32'h3000;
      release_reset();
      for (int k = 0; k < 8; k++) begin
         run(1);
         checks++;
         if (dut.pc !== exp_pc[k]) begin
            errors++; $display("FAIL br_step%0d got %h want %h", k, dut.pc, exp_pc[k]);
         end
      end
   endtask

   task automatic test_r0_illegal();
      logic [31:0] d20;
      d20 = dut.dmem[20];
      hold_reset_and_clear();
      dut.rom[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
      dut.rom[1] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
      dut.rom[2] = {6'h3F, 5'd0, 5'd1, 16'd80};
      dut.rom[3] = enc_r(6'h21, 5'd1, 5'd1, 5'd1);
      dut.rom[4] = enc_r(6'h20, 5'd0, 5'd1, 5'd2);
      release_reset();
      run(5);
      checks++;
      if (dut.rf[0] !== 32'h0) begin
         errors++; $display("FAIL r0_write got %h want %h", dut.rf[0], 32'h0);
      end
      checks++;
      if (dut.rf[1] !== 32'd9) begin
         errors++; $display("FAIL illegal_r1 got %h want %h", dut.rf[1], 32'd9);
      end
      checks++;
      if (dut.rf[2] !== 32'd9) begin
         errors++; $display("FAIL r0_reads_zero got %h want %h", dut.rf[2], 32'd9);
      end
      checks++;
      if (dut.dmem[20] !== d20) begin
         errors++; $display("FAIL illegal_dmem got %h want %h", dut.dmem[20], d20);
      end
      checks++;
      if (dut.pc !== 32'h0000_3014) begin
         errors++; $display("FAIL illegal_pc got %h want %h", dut.pc, 32'h0000_3014);
      end
   endtask

   task automatic test_reset_midrun();
      hold_reset_and_clear();
      dut.rom[0] = enc_i(6'h08, 5'd0, 5'd2, 16'h0077);
      dut.rom[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'd96);
      dut.rom[2] = enc_i(6'h08, 5'd2, 5'd3, 16'd1);
      release_reset();
      run(2);
      rst = 1'b0;
      #1;
      checks++;
      if (dut.pc !== 32'h0000_3000) begin
         errors++; $display("FAIL midrst_pc got %h want %h", dut.pc, 32'h0000_3000);
      end
      checks++;
      if (dut.rf[2] !== 32'h0) begin
         errors++; $display("FAIL midrst_rf got %h want %h", dut.rf[2], 32'h0);
      end
      @(posedge clk); #1;
      checks++;
      if (dut.rf[2] !== 32'h0 || dut.pc !== 32'h0000_3000) begin
         errors++; $display("FAIL midrst_held got r2=%h pc=%h want 0 and 3000", dut.rf[2], dut.pc);
      end
      checks++;
      if (dut.dmem[24] !== 32'h77) begin
         errors++; $display("FAIL midrst_dmem24 got %h want %h", dut.dmem[24], 32'h77);
      end
      checks++;
      if (dut.dmem[20] !== 32'h55) begin
         errors++; $display("FAIL midrst_dmem20 got %h want %h", dut.dmem[20], 32'h55);
      end
      release_reset();
      run(1);
      checks++;
      if (dut.pc !== 32'h0000_3004 || dut.rf[2] !== 32'h77) begin
         errors++; $display("FAIL midrst_restart got pc=%h r2=%h want 3004 and 77", dut.pc, dut.rf[2]);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_alu();
      test_memory();
      test_branch_jump();
      test_r0_illegal();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
